// File: rtl/usbfs_in_stream_arbiter.sv
// Round-robin packer that shares bulk IN endpoint 0x81 between NCH byte sources.
// Each burst goes out as a header byte {1, channel, length} followed by the buffered payload.
module usbfs_in_stream_arbiter #(
    parameter int NCH     = 4,
    parameter int BURST   = 31,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [8*NCH-1:0] ch_data,
    input  logic [NCH-1:0]   ch_valid,
    input  logic [NCH-1:0]   ch_last,
    output logic [NCH-1:0]   ch_ready,
    output logic [7:0]       in_data,
    output logic             in_valid,
    input  logic             in_ready
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_HDR   = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t         r_state;
    state_t         w_next_state;
    logic [1:0]     r_rr;
    logic [1:0]     r_grant;
    logic [1:0]     w_grant_nxt;
    logic [1:0]     w_pick;
    logic           w_any;
    logic [4:0]     r_cnt;
    logic [4:0]     r_rd;
    logic [7:0]     r_tmo;
    logic [7:0]     r_buf [BURST];
    logic [NCH-1:0] r_ch_ready;
    logic [NCH-1:0] w_ready_nxt;
    logic           r_in_valid;
    logic [7:0]     w_src_byte;
    logic           w_src_valid;
    logic           w_src_last;
    logic           w_src_ready;
    logic           w_accept;
    logic           w_take;
    int             w_dist;
    int             w_best;

    assign w_any    = |ch_valid;
    assign w_accept = w_src_valid & w_src_ready;
    assign ch_ready = r_ch_ready;
    assign in_valid = r_in_valid;

    // Round-robin search: the valid channel closest after r_rr wins.
    always_comb begin
        w_pick = r_rr;
        w_best = NCH;
        w_dist = 0;
        w_take = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            w_dist = (i + NCH - 1 - int'(r_rr)) % NCH;
            w_take = ch_valid[i] && (w_dist < w_best);
            w_pick = w_take ? 2'(i) : w_pick;
            w_best = w_take ? w_dist : w_best;
        end
    end

    // Select the granted channel's handshake signals.
    always_comb begin
        w_src_byte  = 8'h00;
        w_src_valid = 1'b0;
        w_src_last  = 1'b0;
        w_src_ready = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            w_src_byte  = (r_grant == 2'(i)) ? ch_data[8*i +: 8] : w_src_byte;
            w_src_valid = (r_grant == 2'(i)) ? ch_valid[i]       : w_src_valid;
            w_src_last  = (r_grant == 2'(i)) ? ch_last[i]        : w_src_last;
            w_src_ready = (r_grant == 2'(i)) ? r_ch_ready[i]     : w_src_ready;
        end
    end

    // Next-state decode for the burst scheduler.
    always_comb begin
        w_next_state = r_state;
        w_grant_nxt  = r_grant;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_next_state = S_FILL;
                    w_grant_nxt  = w_pick;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_FILL: begin
                if (w_accept) begin
                    if (w_src_last || (r_cnt == 5'(BURST - 1))) begin
                        w_next_state = S_HDR;
                    end else begin
                        w_next_state = S_FILL;
                    end
                end else if (r_tmo == 8'(TIMEOUT - 1)) begin
                    // An empty burst that times out is dropped silently.
                    if (r_cnt != 5'd0) begin
                        w_next_state = S_HDR;
                    end else begin
                        w_next_state = S_IDLE;
                    end
                end else begin
                    w_next_state = S_FILL;
                end
            end
            S_HDR: begin
                if (in_ready) begin
                    w_next_state = S_DRAIN;
                end else begin
                    w_next_state = S_HDR;
                end
            end
            S_DRAIN: begin
                if (in_ready && (r_rd == r_cnt - 5'd1)) begin
                    w_next_state = S_IDLE;
                end else begin
                    w_next_state = S_DRAIN;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Source ready for the next cycle is a one-hot decode of the next grant in FILL.
    always_comb begin
        w_ready_nxt = '0;
        for (int i = 0; i < NCH; i++) begin
            w_ready_nxt[i] = (w_next_state == S_FILL) && (w_grant_nxt == 2'(i));
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Scheduler counters and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_rr       <= 2'(NCH - 1);
            r_grant    <= 2'd0;
            r_cnt      <= 5'd0;
            r_rd       <= 5'd0;
            r_tmo      <= 8'd0;
            r_ch_ready <= '0;
            r_in_valid <= 1'b0;
        end else begin
            r_ch_ready <= w_ready_nxt;
            r_in_valid <= (w_next_state == S_HDR) || (w_next_state == S_DRAIN);
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_rr    <= w_pick;
                        r_grant <= w_pick;
                        r_cnt   <= 5'd0;
                        r_tmo   <= 8'd0;
                    end
                end
                S_FILL: begin
                    if (w_accept) begin
                        r_cnt <= r_cnt + 5'd1;
                        r_tmo <= 8'd0;
                    end else begin
                        r_tmo <= r_tmo + 8'd1;
                    end
                end
                S_HDR: begin
                    if (in_ready) begin
                        r_rd <= 5'd0;
                    end
                end
                S_DRAIN: begin
                    if (in_ready) begin
                        r_rd <= r_rd + 5'd1;
                    end
                end
                default: begin
                    r_rd <= 5'd0;
                end
            endcase
        end
    end

    // Staging buffer; contents are only meaningful below r_cnt.
    always_ff @(posedge clk) begin
        if ((r_state == S_FILL) && w_accept) begin
            r_buf[r_cnt] <= w_src_byte;
        end
    end

    // Endpoint byte is a mux of registered header fields or buffer entry.
    always_comb begin
        case (r_state)
            S_HDR:   in_data = {1'b1, r_grant, r_cnt};
            S_DRAIN: in_data = r_buf[r_rd];
            default: in_data = 8'h00;
        endcase
    end

endmodule
